// File: rtl/parking_pkg.sv
// parking_pkg: shared gate state encoding and statistics width for the parking gate controller.
package parking_pkg;
  typedef enum logic [1:0] {IDLE, OPEN, GUARD} gate_state_e;
  localparam int STATS_W = 16;
endpackage

// File: rtl/parking_gate_ctrl_occupancy.sv
// occupancy_counter: up/down cars-inside counter that discards over/underflow events with a seq_err pulse.
module occupancy_counter #(
  parameter int CAPACITY = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             car_in_i,
  input  logic             car_out_i,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             seq_err_o
);
  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic full_q, err_q, err_d, inc, dec;
  assign inc = car_in_i & ~car_out_i;
  assign dec = car_out_i & ~car_in_i;
  always_comb begin
    err_d = (inc && cnt_q == CAP) || (dec && cnt_q == '0);
    cnt_d = err_d ? cnt_q : inc ? cnt_q + 1'b1 : dec ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= cnt_d == CAP;
      err_q  <= err_d;
    end
  end
  assign count_o   = cnt_q;
  assign full_o    = full_q;
  assign seq_err_o = err_q;
endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: occupancy tracking plus entry barrier FSM (IDLE/OPEN/GUARD).
// Define PARKING_STATS_EN to build the total_in/reject_cnt statistics counters.
module parking_gate_ctrl import parking_pkg::*; #(
  parameter int CAPACITY     = 8,
  parameter int CNT_W        = 4,
  parameter int OPEN_TIMEOUT = 100,
  parameter int GUARD_CYCLES = 4,
  parameter int TMR_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               car_in,
  input  logic               car_out,
  input  logic               entry_req,
  output logic               gate_open,
  output logic               full,
  output logic [CNT_W-1:0]   occupancy,
  output logic               denied,
  output logic               timeout,
  output logic               seq_err,
  output logic [STATS_W-1:0] total_in,
  output logic [STATS_W-1:0] reject_cnt
);
  gate_state_e state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic req_q, gate_q, denied_q, denied_d, timeout_q, timeout_d;
  occupancy_counter #(.CAPACITY(CAPACITY), .CNT_W(CNT_W)) u_occ (
    .clk       (clk),
    .reset     (reset),
    .car_in_i  (car_in),
    .car_out_i (car_out),
    .count_o   (occupancy),
    .full_o    (full),
    .seq_err_o (seq_err)
  );
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q + 1'b1;
    denied_d  = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_d    = '0;
        state_d  = (entry_req && !full) ? OPEN : IDLE;
        denied_d = entry_req && !req_q && full;
      end
      OPEN: begin
        if (car_in) begin
          state_d = GUARD;
          tmr_d   = '0;
        end else if (tmr_q == TMR_W'(OPEN_TIMEOUT - 1)) begin
          state_d   = IDLE;
          tmr_d     = '0;
          timeout_d = 1'b1;
        end
      end
      GUARD: begin
        if (tmr_q == TMR_W'(GUARD_CYCLES - 1)) begin
          state_d = IDLE;
          tmr_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      req_q     <= 1'b0;
      gate_q    <= 1'b0;
      denied_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      req_q     <= entry_req;
      gate_q    <= state_d != IDLE;
      denied_q  <= denied_d;
      timeout_q <= timeout_d;
    end
  end
  assign gate_open = gate_q;
  assign denied    = denied_q;
  assign timeout   = timeout_q;
`ifdef PARKING_STATS_EN
  logic [STATS_W-1:0] tin_q, rej_q;
  logic in_ok;
  // car_in is only rejected when it would overflow a full lot without a matching car_out
  assign in_ok = car_in && (car_out || occupancy != CNT_W'(CAPACITY));
  always_ff @(posedge clk) begin
    if (reset) begin
      tin_q <= '0;
      rej_q <= '0;
    end else begin
      tin_q <= tin_q + STATS_W'(in_ok);
      rej_q <= rej_q + STATS_W'(denied_d);
    end
  end
  assign total_in   = tin_q;
  assign reject_cnt = rej_q;
`else
  assign total_in   = '0;
  assign reject_cnt = '0;
`endif
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: scoreboarded directed + random bench against a countdown-based reference model.
module tb_parking_gate_ctrl;
  localparam int CAP = 8;
  localparam int OT  = 100;
  localparam int GC  = 4;
  logic clk = 1'b0;
  logic reset, car_in, car_out, entry_req;
  logic gate_open, full, denied, timeout, seq_err;
  logic [3:0] occupancy;
  logic [15:0] total_in, reject_cnt;
  typedef struct {
    int gate, full, occ, den, tmo, err, tin, rej;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int m_occ, m_phase, m_left, m_req, m_full, m_tin, m_rej;
  bit rq_lvl;
  parking_gate_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .car_in     (car_in),
    .car_out    (car_out),
    .entry_req  (entry_req),
    .gate_open  (gate_open),
    .full       (full),
    .occupancy  (occupancy),
    .denied     (denied),
    .timeout    (timeout),
    .seq_err    (seq_err),
    .total_in   (total_in),
    .reject_cnt (reject_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  // phase 0 = lowered, 1 = waiting for a car, 2 = post-entry hold; m_left counts edges remaining
  task automatic step(input bit r, input bit ci, input bit co, input bit rq);
    exp_t e;
    reset = r; car_in = ci; car_out = co; entry_req = rq;
    e.den = 0; e.tmo = 0; e.err = 0;
    if (r) begin
      m_occ = 0; m_phase = 0; m_left = 0; m_req = 0; m_full = 0; m_tin = 0; m_rej = 0;
    end else begin
      if (ci && !co && m_occ == CAP) e.err = 1;
      else if (co && !ci && m_occ == 0) e.err = 1;
      else m_occ += int'(ci) - int'(co);
      if (ci && !e.err) m_tin = (m_tin + 1) % 65536;
      if (m_phase == 0) begin
        if (rq && !m_full) begin m_phase = 1; m_left = OT; end
        else if (rq && !m_req && m_full) begin e.den = 1; m_rej = (m_rej + 1) % 65536; end
      end else if (m_phase == 1) begin
        if (ci) begin m_phase = 2; m_left = GC; end
        else begin
          m_left--;
          if (m_left == 0) begin m_phase = 0; e.tmo = 1; end
        end
      end else begin
        m_left--;
        if (m_left == 0) m_phase = 0;
      end
      m_full = (m_occ == CAP);
      m_req = rq;
    end
    e.gate = (m_phase != 0);
    e.full = m_full;
    e.occ  = m_occ;
`ifdef PARKING_STATS_EN
    e.tin = m_tin; e.rej = m_rej;
`else
    e.tin = 0; e.rej = 0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("gate_open", int'(gate_open), e.gate);
      chk("full", int'(full), e.full);
      chk("occupancy", int'(occupancy), e.occ);
      chk("denied", int'(denied), e.den);
      chk("timeout", int'(timeout), e.tmo);
      chk("seq_err", int'(seq_err), e.err);
      chk("total_in", int'(total_in), e.tin);
      chk("reject_cnt", int'(reject_cnt), e.rej);
    end
  end
  initial begin
    repeat (2) step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (9) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (6) step(0, 0, 0, 0);
    repeat (102) step(0, 0, 0, 1);
    repeat (105) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (37) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    repeat (8) step(0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (3) step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    repeat (6) step(0, 0, 1, 0);
    rq_lvl = 0;
    for (int i = 0; i < 4000; i++) begin
      bit heavy_in;
      heavy_in = ((i / 500) % 2) == 0;
      if ($urandom_range(0, 7) == 0) rq_lvl = ~rq_lvl;
      step($urandom_range(0, 299) == 0,
           heavy_in ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0),
           heavy_in ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 2) == 0),
           rq_lvl);
    end
    step(0, 0, 0, 0);
    #10;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
